// File: rtl/symbol_to_key_player.sv
// -----------------------------------------------------------------------------
// symbol_to_key_player
//
// Replays ASCII symbols from the host link as timed one-hot keypad presses.
// Each accepted symbol drives its key for HOLD_CYCLES clocks. The key is then
// released (all-zero) for GAP_CYCLES clocks before the next symbol is taken.
//
// Parameters
//   HOLD_CYCLES   clocks the one-hot key stays asserted per press (>=1)
//   GAP_CYCLES    clocks of all-zero key after release (>=1)
//
// Ports
//   Clock         in   system clock, all state on rising edge
//   Reset         in   asynchronous, active-high reset
//   BFISA         in   1 = Brainfuck symbol set, 0 = native set; sampled at accept
//   symbol        in   [7:0] ASCII symbol from host
//   symbol_valid  in   symbol present
//   symbol_ready  out  block can accept (transfer = valid & ready)
//   numericKey    out  [15:0] one-hot key press, all-zero when released
//   busy          out  1 while pressing or in the release gap
//   bad_symbol    out  one-clock pulse when an accepted symbol has no mapping
//
// Build option
//   SYMBOL_TO_KEY_CASE_FOLD_EN : when defined, lowercase 0x61..0x7A is folded
//   to uppercase before decode. When it is not defined, lowercase is unmapped.
//
// States
//   IDLE  | waiting for a symbol, symbol_ready high
//   PRESS | decoded key held on numericKey
//   GAP   | key released, waiting before the next accept
// -----------------------------------------------------------------------------
module symbol_to_key_player #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        BFISA,
    input  logic [7:0]  symbol,
    input  logic        symbol_valid,
    output logic        symbol_ready,
    output logic [15:0] numericKey,
    output logic        busy,
    output logic        bad_symbol
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    sym_f;
    logic [15:0]   key_dec;

    // Optional lowercase fold ahead of the decode table.
    always_comb begin
        sym_f = symbol;
`ifdef SYMBOL_TO_KEY_CASE_FOLD_EN
        if (symbol >= 8'h61 && symbol <= 8'h7A) begin
            sym_f = symbol - 8'h20;
        end
`endif
    end

    // Symbol -> one-hot key. Bits 6..9 depend on the ISA selected at accept.
    // An all-zero result means the symbol has no key.
    always_comb begin
        key_dec = 16'h0000;
        case (sym_f)
            8'h4E: key_dec[0]  = 1'b1;
            8'h48: key_dec[1]  = 1'b1;
            8'h2B: key_dec[2]  = 1'b1;
            8'h2D: key_dec[3]  = 1'b1;
            8'h3C: key_dec[4]  = 1'b1;
            8'h3E: key_dec[5]  = 1'b1;
            8'h5B: key_dec[6]  = BFISA;
            8'h28: key_dec[6]  = ~BFISA;
            8'h5D: key_dec[7]  = BFISA;
            8'h29: key_dec[7]  = ~BFISA;
            8'h2E: key_dec[8]  = BFISA;
            8'h4C: key_dec[8]  = ~BFISA;
            8'h2C: key_dec[9]  = BFISA;
            8'h49: key_dec[9]  = ~BFISA;
            8'h30: key_dec[10] = 1'b1;
            8'h40: key_dec[11] = 1'b1;
            8'h43: key_dec[12] = 1'b1;
            8'h44: key_dec[13] = 1'b1;
            8'h4D: key_dec[14] = 1'b1;
            8'h42: key_dec[15] = 1'b1;
            default: key_dec = 16'h0000;
        endcase
    end

    // Ready is gated by Reset so the host sees it low for the whole reset.
    assign symbol_ready = (state == S_IDLE) & ~Reset;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            numericKey <= 16'h0000;
            busy       <= 1'b0;
            bad_symbol <= 1'b0;
        end else begin
            bad_symbol <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (symbol_valid) begin
                        if (key_dec != 16'h0000) begin
                            state      <= S_PRESS;
                            numericKey <= key_dec;
                            cnt        <= HOLD_LOAD;
                            busy       <= 1'b1;
                        end else if (symbol != 8'h00) begin
                            // NUL is a filler character, so it is dropped without an error.
                            bad_symbol <= 1'b1;
                        end
                    end
                end
                S_PRESS: begin
                    if (cnt == '0) begin
                        state      <= S_GAP;
                        numericKey <= 16'h0000;
                        cnt        <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    cnt        <= '0;
                    numericKey <= 16'h0000;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_to_key_player.sv
module tb_symbol_to_key_player;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic        Clock;
    logic        Reset;
    logic        BFISA;
    logic [7:0]  symbol;
    logic        symbol_valid;
    logic        symbol_ready;
    logic [15:0] numericKey;
    logic        busy;
    logic        bad_symbol;

    int nassert = 0;
    int nfail   = 0;

    typedef struct {
        bit          bad;
        logic [15:0] key;
    } ev_t;

    ev_t     exp_q[$];
    realtime xfer_t;

    symbol_to_key_player #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .BFISA       (BFISA),
        .symbol      (symbol),
        .symbol_valid(symbol_valid),
        .symbol_ready(symbol_ready),
        .numericKey  (numericKey),
        .busy        (busy),
        .bad_symbol  (bad_symbol)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nassert++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_key(input logic [15:0] k);
        ev_t e;
        e.bad = 1'b0;
        e.key = k;
        exp_q.push_back(e);
    endtask

    task automatic push_bad();
        ev_t e;
        e.bad = 1'b1;
        e.key = 16'h0000;
        exp_q.push_back(e);
    endtask

    // Called in the negedge phase. Waits (bounded) for ready, completes one
    // transfer on the next rising edge, and returns in the following negedge phase.
    task automatic xfer(input logic [7:0] s, input logic bf, input bit keep_valid);
        int n;
        n = 0;
        symbol       = s;
        BFISA        = bf;
        symbol_valid = 1'b1;
        while (!symbol_ready && n < 50) begin
            @(negedge Clock);
            n++;
        end
        chk("ready_wait_timeout", (n < 50), 1);
        @(posedge Clock);
        xfer_t = $realtime;
        #1;
        if (!keep_valid) symbol_valid = 1'b0;
        @(negedge Clock);
    endtask

    // Scoreboard monitor: pops an expected event on each new press or bad
    // pulse, and checks that the key is stable, one-hot and held for HOLD clocks.
    logic [15:0] prev_key = 16'h0000;
    int          hold_cnt = 0;
    always @(negedge Clock) begin
        ev_t e;
        if (Reset) begin
            prev_key = 16'h0000;
            hold_cnt = 0;
        end else begin
            if (numericKey != 16'h0000 && prev_key == 16'h0000) begin
                chk("press_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("event_is_press", e.bad, 1'b0);
                    chk("key_value", numericKey, e.key);
                end
                hold_cnt = 1;
            end else if (numericKey != 16'h0000) begin
                chk("key_stable", numericKey, prev_key);
                hold_cnt++;
            end else if (prev_key != 16'h0000) begin
                chk("hold_length", hold_cnt, HOLD);
                hold_cnt = 0;
            end
            if (numericKey != 16'h0000) chk("one_hot", $countones(numericKey), 1);
            if (bad_symbol) begin
                chk("bad_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("event_is_bad", e.bad, 1'b1);
                end
            end
            prev_key = numericKey;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        realtime t_prev;
        logic [15:0] k_tab  [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
        logic        r_tab  [7] = '{0, 0, 0, 0, 0, 0, 1};
        logic        b_tab  [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [7:0]  stream [4] = '{8'h2B, 8'h2D, 8'h3C, 8'h3E};
        logic [15:0] skeys  [4] = '{16'h0004, 16'h0008, 16'h0010, 16'h0020};

        Reset = 1'b1; BFISA = 1'b0; symbol = 8'h00; symbol_valid = 1'b0;
        #1;
        chk("rst_ready", symbol_ready, 1'b0);
        chk("rst_key", numericKey, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bad", bad_symbol, 1'b0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("post_rst_ready", symbol_ready, 1'b1);
        @(negedge Clock);

        // 'N' timing: key for HOLD clocks, zero for GAP, then ready again
        push_key(16'h0001);
        xfer(8'h4E, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            chk("n_key", numericKey, k_tab[i]);
            chk("n_ready", symbol_ready, r_tab[i]);
            chk("n_busy", busy, b_tab[i]);
            if (i < 6) @(negedge Clock);
        end
        // ready visible in this phase, so the next transfer edge is T+HOLD+GAP+1
        chk("n_ready_edge", int'(($realtime + 5 - xfer_t) / 10), HOLD + GAP + 1);

        // ISA-dependent bit 6 and an other-ISA symbol
        push_key(16'h0040);
        xfer(8'h5B, 1'b1, 0);
        push_key(16'h0040);
        xfer(8'h28, 1'b0, 0);
        push_bad();
        xfer(8'h5B, 1'b0, 0);
        chk("bad_pulse", bad_symbol, 1'b1);
        chk("bad_key", numericKey, 16'h0000);
        chk("bad_ready", symbol_ready, 1'b1);
        @(negedge Clock);
        chk("bad_pulse_end", bad_symbol, 1'b0);
        chk("bad_busy", busy, 1'b0);

        // Stream "+-<>" with valid held high; symbol changes while busy are ignored
        for (int i = 0; i < 4; i++) begin
            push_key(skeys[i]);
            t_prev = xfer_t;
            xfer(stream[i], 1'b0, 1);
            if (i > 0) chk("stream_period", int'((xfer_t - t_prev) / 10), HOLD + GAP + 1);
        end
        symbol_valid = 1'b0;
        repeat (HOLD + GAP + 1) @(negedge Clock);

        // Async reset on the second press clock of 'B'
        push_key(16'h8000);
        xfer(8'h42, 1'b0, 0);
        @(negedge Clock);
        chk("b_key_before_rst", numericKey, 16'h8000);
        Reset = 1'b1;
        #1;
        chk("midrst_key", numericKey, 16'h0000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", symbol_ready, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("after_rst_ready", symbol_ready, 1'b1);
        chk("after_rst_busy", busy, 1'b0);
        @(negedge Clock);

        // NUL filler: nothing happens
        xfer(8'h00, 1'b0, 0);
        chk("nul_bad", bad_symbol, 1'b0);
        chk("nul_ready", symbol_ready, 1'b1);
        chk("nul_busy", busy, 1'b0);
        @(negedge Clock);
        chk("nul_key", numericKey, 16'h0000);

        // Lowercase 'n'
`ifdef SYMBOL_TO_KEY_CASE_FOLD_EN
        push_key(16'h0001);
        xfer(8'h6E, 1'b0, 0);
        chk("lower_n_key", numericKey, 16'h0001);
`else
        push_bad();
        xfer(8'h6E, 1'b0, 0);
        chk("lower_n_bad", bad_symbol, 1'b1);
        chk("lower_n_key", numericKey, 16'h0000);
`endif
        repeat (HOLD + GAP + 1) @(negedge Clock);

        // BFISA toggling mid-press does not change the held key
        push_key(16'h0100);
        xfer(8'h2E, 1'b1, 0);
        for (int i = 0; i < HOLD; i++) begin
            chk("bfisa_toggle_key", numericKey, 16'h0100);
            BFISA = ~BFISA;
            @(negedge Clock);
        end
        chk("bfisa_release", numericKey, 16'h0000);

        repeat (HOLD + GAP + 2) @(negedge Clock);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
